// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the halfword/word widths, the loader FSM state enum and the image bound.
package program_loader_pkg;

    localparam int HALF_WORD_W = 16;
    localparam int WORD_W      = 32;

    // Largest image accepted; matches the instruction RAM depth.
    localparam int LOADER_MAX_HALFWORDS = 512;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    // States in which the loader consumes stream bytes.
    function automatic logic is_receiving(loader_state_e s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) ||
               (s == DATA_HI) || (s == CHECK);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (length, LE halfwords, XOR checksum),
// writes each halfword to instruction memory and holds the core until a good load.
// Ports:
//   clk_i, reset_n_i (async active-low), start_i         - control
//   byte_valid_i, byte_i, byte_ready_o                   - byte stream handshake
//   program_mem_write_en_o, instruction_o, instruction_addr_o - memory write port
//   cpu_hold_o, busy_o, load_done_o, error_o             - status
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR     = '0,
    parameter int                MAX_HALFWORDS = LOADER_MAX_HALFWORDS
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    output logic                   byte_ready_o,
    output logic                   program_mem_write_en_o,
    output logic [HALF_WORD_W-1:0] instruction_o,
    output logic [WORD_W-1:0]      instruction_addr_o,
    output logic                   cpu_hold_o,
    output logic                   busy_o,
    output logic                   load_done_o,
    output logic                   error_o
);

    loader_state_e state;
    loader_state_e state_next;

    logic [7:0]  len_lo;
    logic [7:0]  low_byte;
    logic [7:0]  chk;
    logic [15:0] remaining;
    logic [15:0] len_n;
    logic        len_bad;
    logic        chk_ok;
    logic        xfer;
    logic        start_ok;

    assign xfer     = byte_valid_i && byte_ready_o;
    assign len_n    = {byte_i, len_lo};
    assign len_bad  = (len_n == 16'd0) || (int'(len_n) > MAX_HALFWORDS);
    assign chk_ok   = (byte_i == chk);
    assign start_ok = start_i &&
                      ((state == IDLE) || (state == DONE) || (state == ERROR));

    always_comb begin
        state_next   = state;
        byte_ready_o = is_receiving(state);
        busy_o       = is_receiving(state);
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start_i) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_next = len_bad ? ERROR : DATA_LO;
            end
            DATA_LO: begin
                if (xfer) state_next = DATA_HI;
            end
            DATA_HI: begin
                if (xfer) state_next = (remaining == 16'd1) ? CHECK : DATA_LO;
            end
            CHECK: begin
                if (xfer) state_next = chk_ok ? DONE : ERROR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_next;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            len_lo                 <= '0;
            low_byte               <= '0;
            chk                    <= '0;
            remaining              <= '0;
            program_mem_write_en_o <= 1'b0;
            instruction_o          <= '0;
            instruction_addr_o     <= BASE_ADDR;
            cpu_hold_o             <= 1'b1;
            load_done_o            <= 1'b0;
            error_o                <= 1'b0;
        end else begin
            program_mem_write_en_o <= 1'b0;
            load_done_o            <= 1'b0;

            // Address moves on only after the strobe cycle has been seen.
            if (program_mem_write_en_o)
                instruction_addr_o <= instruction_addr_o + 1'b1;

            if (start_ok) begin
                remaining          <= '0;
                chk                <= '0;
                error_o            <= 1'b0;
                instruction_addr_o <= BASE_ADDR;
                cpu_hold_o         <= 1'b1;
            end

            if (xfer) begin
                unique case (state)
                    LEN_LO: len_lo <= byte_i;
                    LEN_HI: begin
                        remaining <= len_n;
                        if (len_bad) error_o <= 1'b1;
                    end
                    DATA_LO: begin
                        low_byte <= byte_i;
                        chk      <= chk ^ byte_i;
                    end
                    DATA_HI: begin
                        instruction_o          <= {byte_i, low_byte};
                        program_mem_write_en_o <= 1'b1;
                        remaining              <= remaining - 16'd1;
                        chk                    <= chk ^ byte_i;
                    end
                    CHECK: begin
                        if (chk_ok) begin
                            load_done_o <= 1'b1;
                            cpu_hold_o  <= 1'b0;
                        end else begin
                            error_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (base 0 and 0x100)
// share one stimulus stream; a scoreboard queue per instance checks every write.
module tb_program_loader;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;

    logic        ready0, we0, hold0, busy0, done0, err0;
    logic [15:0] ins0;
    logic [31:0] addr0;
    logic        ready1, we1, hold1, busy1, done1, err1;
    logic [15:0] ins1;
    logic [31:0] addr1;

    int vectors = 0;
    int miscompares = 0;

    logic [47:0] q0[$];
    logic [47:0] q1[$];
    logic [31:0] exp_addr0, exp_addr1;
    logic [31:0] last0, last1;
    int wcnt0 = 0, wcnt1 = 0, dcnt0 = 0, dcnt1 = 0;

    program_loader #(.BASE_ADDR(32'h0)) dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
        .byte_valid_i(valid), .byte_i(data), .byte_ready_o(ready0),
        .program_mem_write_en_o(we0), .instruction_o(ins0),
        .instruction_addr_o(addr0), .cpu_hold_o(hold0), .busy_o(busy0),
        .load_done_o(done0), .error_o(err0)
    );

    program_loader #(.BASE_ADDR(32'h100)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
        .byte_valid_i(valid), .byte_i(data), .byte_ready_o(ready1),
        .program_mem_write_en_o(we1), .instruction_o(ins1),
        .instruction_addr_o(addr1), .cpu_hold_o(hold1), .busy_o(busy1),
        .load_done_o(done1), .error_o(err1)
    );

    always #5 clk = ~clk;

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        logic [47:0] e;
        if (we0) begin
            wcnt0++;
            last0 = addr0;
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL wr0_unexpected addr=%h data=%h", addr0, ins0);
            end else begin
                e = q0.pop_front();
                if ({addr0, ins0} !== e) begin
                    miscompares++;
                    $display("FAIL wr0 got %h/%h exp %h/%h",
                             addr0, ins0, e[47:16], e[15:0]);
                end
            end
        end
        if (we1) begin
            wcnt1++;
            last1 = addr1;
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL wr1_unexpected addr=%h data=%h", addr1, ins1);
            end else begin
                e = q1.pop_front();
                if ({addr1, ins1} !== e) begin
                    miscompares++;
                    $display("FAIL wr1 got %h/%h exp %h/%h",
                             addr1, ins1, e[47:16], e[15:0]);
                end
            end
        end
        if (done0) dcnt0++;
        if (done1) dcnt1++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        exp_addr0 = 32'h0;
        exp_addr1 = 32'h100;
        wcnt0 = 0; wcnt1 = 0; dcnt0 = 0; dcnt1 = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps,
                             input bit starts);
        bit ok = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                valid = 1'b0;
                start = starts && ($urandom_range(0, 1) == 1);
            end
        end
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ready0 === 1'b1) ok = 1'b1;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        #1 valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept got ready=0 exp ready=1 byte=%h", b);
        end
    endtask

    task automatic send_frame(input bytes_t f, input bit gaps,
                              input bit starts);
        int n;
        bit len_ok;
        n = int'({f[1], f[0]});
        len_ok = (n != 0) && (n <= 512);
        for (int i = 0; i < f.size(); i++) begin
            if (len_ok && i >= 3 && i <= 2 * n + 1 && ((i - 2) % 2 == 1)) begin
                q0.push_back({exp_addr0, f[i], f[i-1]});
                q1.push_back({exp_addr1, f[i], f[i-1]});
                exp_addr0++;
                exp_addr1++;
            end
            send_byte(f[i], gaps, starts);
        end
    endtask

    // Call right after the final byte transfer of a session.
    task automatic check_end(input bit ok, input int writes, string tag);
        @(negedge clk);
        vectors += 4;
        if (done0 !== ok) begin
            miscompares++;
            $display("FAIL %s_done got %b exp %b", tag, done0, ok);
        end
        if (hold0 !== !ok || hold1 !== !ok) begin
            miscompares++;
            $display("FAIL %s_hold got %b/%b exp %b", tag, hold0, hold1, !ok);
        end
        if (err0 !== !ok || err1 !== !ok) begin
            miscompares++;
            $display("FAIL %s_err got %b/%b exp %b", tag, err0, err1, !ok);
        end
        if (busy0 !== 1'b0 || ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle got busy=%b ready=%b exp 0/0",
                     tag, busy0, ready0);
        end
        repeat (3) @(negedge clk);
        #1;
        vectors += 3;
        if (dcnt0 !== int'(ok) || dcnt1 !== int'(ok)) begin
            miscompares++;
            $display("FAIL %s_done_count got %0d/%0d exp %0d",
                     tag, dcnt0, dcnt1, int'(ok));
        end
        if (wcnt0 !== writes || wcnt1 !== writes) begin
            miscompares++;
            $display("FAIL %s_writes got %0d/%0d exp %0d",
                     tag, wcnt0, wcnt1, writes);
        end
        if (q0.size() != 0 || q1.size() != 0 || hold0 !== !ok) begin
            miscompares++;
            $display("FAIL %s_pending got q=%0d/%0d hold=%b exp 0/0 hold=%b",
                     tag, q0.size(), q1.size(), hold0, !ok);
        end
    endtask

    task automatic check_reset_vals(string tag);
        vectors++;
        if ({ready0, we0, busy0, done0, err0, hold0} !== 6'b000001 ||
            ins0 !== 16'h0 || addr0 !== 32'h0 || addr1 !== 32'h100) begin
            miscompares++;
            $display("FAIL %s got rdy%b we%b bsy%b dn%b er%b hd%b i=%h a=%h/%h exp 000001 0 0/100",
                     tag, ready0, we0, busy0, done0, err0, hold0,
                     ins0, addr0, addr1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");
    endtask

    task automatic test_good_load();
        do_start();
        send_frame('{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                     8'h01, 8'h00, 8'h41}, 1'b0, 1'b0);
        check_end(1'b1, 3, "good");
    endtask

    task automatic test_bad_checksum();
        do_start();
        send_frame('{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                     8'h01, 8'h00, 8'h40}, 1'b0, 1'b0);
        check_end(1'b0, 3, "badchk");
    endtask

    task automatic test_bad_length();
        do_start();
        send_frame('{8'h00, 8'h00}, 1'b0, 1'b0);
        check_end(1'b0, 0, "len0");
        do_start();
        send_frame('{8'h01, 8'h02}, 1'b0, 1'b0);
        check_end(1'b0, 0, "len513");
    endtask

    task automatic test_gaps_and_starts();
        for (int r = 0; r < 3; r++) begin
            do_start();
            send_frame('{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                         8'h01, 8'h00, 8'h41}, 1'b1, 1'b1);
            check_end(1'b1, 3, "gaps");
        end
    endtask

    task automatic test_mid_reset();
        do_start();
        send_frame('{8'h03, 8'h00, 8'h34, 8'h12}, 1'b0, 1'b0);
        vectors++;
        if (we0 !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_strobe got %b exp 1", we0);
        end
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset_n = 1'b1;
        test_good_load();
    endtask

    task automatic test_full_image();
        bytes_t f;
        logic [7:0] c = 8'h00;
        logic [15:0] h;
        f.push_back(8'h00);
        f.push_back(8'h02);
        for (int i = 0; i < 512; i++) begin
            h = 16'(i);
            f.push_back(h[7:0]);
            f.push_back(h[15:8]);
            c = c ^ h[7:0] ^ h[15:8];
        end
        f.push_back(c);
        do_start();
        send_frame(f, 1'b0, 1'b0);
        check_end(1'b1, 512, "full");
        vectors++;
        if (last1 !== 32'h2FF || last0 !== 32'h1FF) begin
            miscompares++;
            $display("FAIL full_last_addr got %h/%h exp 1ff/2ff", last0, last1);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_length();
        test_gaps_and_starts();
        test_mid_reset();
        test_full_image();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
